// File: rtl/mem_responder_if.sv
// Core <-> memory bus plus preload port and status outputs of mem_responder.
// Latency: none (wires only); read data is registered inside the responder.
// Backpressure: none; the responder accepts one request per cycle.
interface mem_responder_if;
  logic [31:0] memop;
  logic [31:0] memaddress;
  logic [31:0] memoutdata;
  logic [31:0] memindata;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  // Core / boot-loader side drives requests and observes results.
  modport master (
    output memop, memaddress, memoutdata, load_en, load_addr, load_data,
    input  memindata, err, rd_count, wr_count
  );

  // Memory side answers requests.
  modport slave (
    input  memop, memaddress, memoutdata, load_en, load_addr, load_data,
    output memindata, err, rd_count, wr_count
  );
endinterface

// File: rtl/mem_responder.sv
// Memory endpoint: text + data word RAMs, word/byte writes, preload port, sticky error flag.
// Latency: read sampled at edge N is on memindata after edge N; writes land at the sampling edge.
// Backpressure: none; one request per cycle, preload wins over a core write in the same cycle.
module mem_responder #(
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter int          TEXT_WORDS = 1024,
  parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
  parameter int          DATA_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  mem_responder_if.slave bus
);

  localparam int TAW = $clog2(TEXT_WORDS);
  localparam int DAW = $clog2(DATA_WORDS);
  // 33-bit region ends so a region touching the top of the address space cannot wrap.
  localparam logic [32:0] TEXT_END = {1'b0, TEXT_BASE} + 33'(4 * TEXT_WORDS);
  localparam logic [32:0] DATA_END = {1'b0, DATA_BASE} + 33'(4 * DATA_WORDS);

  localparam logic [31:0] OP_IDLE  = 32'd0;
  localparam logic [31:0] OP_READ  = 32'd1;
  localparam logic [31:0] OP_WRW   = 32'd2;
  localparam logic [31:0] OP_WRB   = 32'd3;

  typedef enum logic {IDLE, RESP} state_t;

  logic [31:0] text_mem [TEXT_WORDS];
  logic [31:0] data_mem [DATA_WORDS];

  state_t      state_q, state_d;
  logic [31:0] memindata_q, memindata_d;
  logic        err_q, err_d;
  logic [15:0] rd_q, rd_d;
  logic [15:0] wr_q, wr_d;

  // Single RAM write port per cycle, shared by preload and core writes.
  logic           we_text, we_data;
  logic [TAW-1:0] we_tidx;
  logic [DAW-1:0] we_didx;
  logic [31:0]    we_word;
  logic [3:0]     we_be;

  function automatic logic in_text(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, TEXT_BASE}) && ({1'b0, a} < TEXT_END);
  endfunction

  function automatic logic in_data(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, DATA_BASE}) && ({1'b0, a} < DATA_END);
  endfunction

  function automatic logic [TAW-1:0] text_idx(input logic [31:0] a);
    return TAW'((a - TEXT_BASE) >> 2);
  endfunction

  function automatic logic [DAW-1:0] data_idx(input logic [31:0] a);
    return DAW'((a - DATA_BASE) >> 2);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  logic c_text, c_data, c_hit, c_misal;
  logic l_text, l_data, l_hit;

  assign c_text  = in_text(bus.memaddress);
  assign c_data  = in_data(bus.memaddress);
  assign c_hit   = c_text | c_data;
  assign c_misal = (bus.memaddress[1:0] != 2'b00);
  assign l_text  = in_text(bus.load_addr);
  assign l_data  = in_data(bus.load_addr);
  assign l_hit   = l_text | l_data;

  // Next-state, read data, error, counters and RAM write-port selection.
  always_comb begin
    state_d     = state_q;
    memindata_d = memindata_q;
    err_d       = err_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    we_text     = 1'b0;
    we_data     = 1'b0;
    we_tidx     = '0;
    we_didx     = '0;
    we_word     = '0;
    we_be       = '0;

    // Preload owns the write port whenever it hits RAM.
    if (bus.load_en) begin
      if (l_hit) begin
        we_text = l_text;
        we_data = l_data;
        we_tidx = text_idx(bus.load_addr);
        we_didx = data_idx(bus.load_addr);
        we_word = bus.load_data;
        we_be   = 4'hF;
        wr_d    = sat_inc(wr_d);
      end else begin
        err_d = 1'b1;
      end
    end

    case (bus.memop)
      OP_IDLE: ;
      OP_READ: begin
        if (c_hit) begin
          // RAM read sees pre-edge contents, so a same-cycle preload is not visible yet.
          memindata_d = c_text ? text_mem[text_idx(bus.memaddress)]
                               : data_mem[data_idx(bus.memaddress)];
          rd_d = sat_inc(rd_d);
          if (c_misal) err_d = 1'b1;
        end else begin
          memindata_d = 32'h0;
          err_d       = 1'b1;
        end
      end
      OP_WRW, OP_WRB: begin
        if (!c_hit) begin
          err_d = 1'b1;
        end else begin
          if (bus.memop == OP_WRW && c_misal) err_d = 1'b1;
          if (!(bus.load_en && l_hit)) begin
            we_text = c_text;
            we_data = c_data;
            we_tidx = text_idx(bus.memaddress);
            we_didx = data_idx(bus.memaddress);
            if (bus.memop == OP_WRW) begin
              we_word = bus.memoutdata;
              we_be   = 4'hF;
            end else begin
              we_word = {4{bus.memoutdata[7:0]}};
              we_be   = 4'b0001 << bus.memaddress[1:0];
            end
            wr_d = sat_inc(wr_d);
          end
        end
      end
      default: err_d = 1'b1;
    endcase

    case (state_q)
      IDLE:    state_d = (bus.memop == OP_READ) ? RESP : IDLE;
      RESP:    state_d = (bus.memop == OP_READ) ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control/status registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      memindata_q <= 32'h0;
      err_q       <= 1'b0;
      rd_q        <= 16'h0;
      wr_q        <= 16'h0;
    end else begin
      state_q     <= state_d;
      memindata_q <= memindata_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
    end
  end

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_text && we_be[b]) text_mem[we_tidx][8*b +: 8] <= we_word[8*b +: 8];
      if (we_data && we_be[b]) data_mem[we_didx][8*b +: 8] <= we_word[8*b +: 8];
    end
  end

  assign bus.memindata = memindata_q;
  assign bus.err       = err_q;
  assign bus.rd_count  = rd_q;
  assign bus.wr_count  = wr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a read-data scoreboard.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
// Expected read words are queued when the read is driven and popped one cycle later.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic core(input logic [31:0] op, input logic [31:0] addr, input logic [31:0] wd);
    bus.memop      = op;
    bus.memaddress = addr;
    bus.memoutdata = wd;
  endtask

  task automatic preload(input logic en, input logic [31:0] addr, input logic [31:0] d);
    bus.load_en   = en;
    bus.load_addr = addr;
    bus.load_data = d;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] expv);
    core(32'd1, addr, 32'h0);
    exp_q.push_back(expv);
  endtask

  // One clock: inputs driven before the call are sampled, then any queued read is checked.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    core(32'd0, 32'h0, 32'h0);
    preload(1'b0, 32'h0, 32'h0);
    if (exp_q.size() > 0) check("rdata", bus.memindata, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    core(32'd0, 32'h0, 32'h0);
    preload(1'b0, 32'h0, 32'h0);
    #2;
    check("rst_rdata", bus.memindata, 32'h0);
    check("rst_err",   32'(bus.err), 32'h0);
    check("rst_rdcnt", 32'(bus.rd_count), 32'h0);
    check("rst_wrcnt", 32'(bus.wr_count), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Preload and first read.
    preload(1'b1, 32'h0040_0000, 32'h3C01_1001); tick();
    preload(1'b1, 32'h0040_0004, 32'h2408_0005); tick();
    check("pre_wrcnt", 32'(bus.wr_count), 32'd2);
    rd(32'h0040_0000, 32'h3C01_1001); tick();
    check("rd1_cnt", 32'(bus.rd_count), 32'd1);

    // Word then byte write merge.
    core(32'd2, 32'h1001_0004, 32'hCAFE_BABE); tick();
    core(32'd3, 32'h1001_0005, 32'hFFFF_FF11); tick();
    rd(32'h1001_0004, 32'hCAFE_11BE); tick();
    check("wr_cnt4", 32'(bus.wr_count), 32'd4);
    check("err_clean", 32'(bus.err), 32'h0);

    // Back-to-back reads.
    rd(32'h0040_0000, 32'h3C01_1001); tick();
    rd(32'h0040_0004, 32'h2408_0005); tick();
    check("b2b_rdcnt", 32'(bus.rd_count), 32'd4);

    // Preload beats a same-cycle core write.
    preload(1'b1, 32'h1001_0008, 32'h1111_2222);
    core(32'd2, 32'h1001_0008, 32'h3333_4444); tick();
    check("prio_wrcnt", 32'(bus.wr_count), 32'd5);
    rd(32'h1001_0008, 32'h1111_2222); tick();

    // Same-cycle read sees old data, next read sees preload.
    preload(1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
    rd(32'h1001_0004, 32'hCAFE_11BE); tick();
    rd(32'h1001_0004, 32'hDEAD_BEEF); tick();
    check("rd_cnt7", 32'(bus.rd_count), 32'd7);
    check("wr_cnt6", 32'(bus.wr_count), 32'd6);
    check("err_still0", 32'(bus.err), 32'h0);

    // Unmapped read.
    rd(32'h2000_0000, 32'h0); tick();
    check("unmap_err", 32'(bus.err), 32'h1);
    check("unmap_rdcnt", 32'(bus.rd_count), 32'd7);
    rd(32'h0040_0000, 32'h3C01_1001); tick();
    check("sticky_err", 32'(bus.err), 32'h1);

    // Misaligned read and bad opcode.
    rd(32'h0040_0002, 32'h3C01_1001); tick();
    check("misal_rdcnt", 32'(bus.rd_count), 32'd9);
    core(32'd7, 32'h0040_0004, 32'h0); tick();
    check("op7_hold", bus.memindata, 32'h3C01_1001);
    check("op7_rdcnt", 32'(bus.rd_count), 32'd9);
    check("op7_wrcnt", 32'(bus.wr_count), 32'd6);
    check("op7_err", 32'(bus.err), 32'h1);

    // Async reset while in RESP with a read pending.
    rd(32'h0040_0004, 32'h2408_0005); tick();
    core(32'd1, 32'h0040_0000, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_rdata", bus.memindata, 32'h0);
    check("arst_err",   32'(bus.err), 32'h0);
    check("arst_rdcnt", 32'(bus.rd_count), 32'h0);
    check("arst_wrcnt", 32'(bus.wr_count), 32'h0);
    @(negedge clk);
    core(32'd0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    check("no_reserve", bus.memindata, 32'h0);
    rd(32'h0040_0004, 32'h2408_0005); tick();
    check("post_rdcnt", 32'(bus.rd_count), 32'd1);

    // Write counter saturation via sustained preload.
    preload(1'b1, 32'h1001_0010, 32'h5555_AAAA);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    preload(1'b0, 32'h0, 32'h0);
    check("wr_sat", 32'(bus.wr_count), 32'h0000_FFFF);
    rd(32'h1001_0010, 32'h5555_AAAA); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
